// File: rtl/fir_tcdm_responder_pkg.sv
// Shared types and sizing helpers for the FIR TCDM responder.
package fir_tcdm_responder_pkg;

    localparam int unsigned TCDM_AW  = 32;
    localparam int unsigned TCDM_DW  = 32;
    localparam int unsigned TCDM_BEW = TCDM_DW / 8;

    // Width of an index over n entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bank-select width for a word-interleaved layout of n_banks banks.
    function automatic int unsigned bank_idx_width(input int unsigned n_banks);
        return idx_width(n_banks);
    endfunction

    // Row-address width for banks of n_words words.
    function automatic int unsigned row_width(input int unsigned n_words);
        return idx_width(n_words);
    endfunction

    // Request fields as routed from the winning port to a bank.
    typedef struct packed {
        logic [TCDM_AW-1:0]  add;
        logic                wen;
        logic [TCDM_BEW-1:0] be;
        logic [TCDM_DW-1:0]  data;
    } fir_tcdm_req_t;

endpackage

// File: rtl/fir_tcdm_responder_if.sv
// HCI core port: request/grant plus registered response channel.
interface fir_tcdm_responder_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
) ();

    logic          req;
    logic          gnt;
    logic [AW-1:0] add;
    logic          wen;
    logic [DW/8-1:0] be;
    logic [DW-1:0] data;
    logic          r_ready;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_user;
    logic          r_id;
    logic          r_opc;
    logic          ecc;

    modport initiator (
        output req, add, wen, be, data, r_ready,
        input  gnt, r_data, r_valid, r_user, r_id, r_opc, ecc
    );

    modport target (
        input  req, add, wen, be, data, r_ready,
        output gnt, r_data, r_valid, r_user, r_id, r_opc, ecc
    );

endinterface

// File: rtl/fir_tcdm_responder_bank.sv
// Single TCDM bank: byte-enabled write, one-cycle registered read.
module fir_tcdm_responder_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NB_WORDS   = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    input  logic                        wen_i,
    input  logic [DATA_WIDTH/8-1:0]     be_i,
    input  logic [$clog2(NB_WORDS)-1:0] row_i,
    input  logic [DATA_WIDTH-1:0]       wdata_i,
    output logic [DATA_WIDTH-1:0]       rdata_o
);

    localparam int unsigned BeW = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [NB_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage array: no reset, only enabled byte lanes are updated (wen=0 is a write).
    always_ff @(posedge clk_i) begin
        if (req_i && !wen_i) begin
            for (int i = 0; i < BeW; i++) begin
                if (be_i[i]) begin
                    mem_q[row_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    // Read register: captures the addressed row on a granted read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (req_i && wen_i) begin
            rdata_q <= mem_q[row_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_tcdm_responder.sv
// Multi-bank TCDM responder: per-bank round-robin arbitration, fixed-latency responses
// and a saturating bank-conflict counter.
module fir_tcdm_responder
    import fir_tcdm_responder_pkg::*;
#(
    parameter int unsigned MP                = 3,
    parameter int unsigned DATA_WIDTH        = TCDM_DW,
    parameter int unsigned N_BANKS           = 4,
    parameter int unsigned NB_WORDS_PER_BANK = 1024,
    parameter int unsigned LATENCY           = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic [MP-1:0]         stall_i,
    fir_tcdm_responder_if.target  tcdm [MP],
    output logic [31:0]           n_conflicts_o
);

    localparam int unsigned OffW  = $clog2(DATA_WIDTH / 8);
    localparam int unsigned BankW = bank_idx_width(N_BANKS);
    localparam int unsigned RowW  = row_width(NB_WORDS_PER_BANK);
    localparam int unsigned PtrW  = idx_width(MP);

    fir_tcdm_req_t         port_req   [MP];
    logic [BankW-1:0]      port_bank  [MP];
    logic [MP-1:0]         req;
    logic [MP-1:0]         elig;
    logic [MP-1:0]         port_gnt_raw;
    logic [MP-1:0]         gnt;
    logic [MP-1:0]         unused_ready;

    logic [N_BANKS-1:0]    bank_gnt;
    logic [PtrW-1:0]       bank_win   [N_BANKS];
    fir_tcdm_req_t         bank_req   [N_BANKS];
    logic [DATA_WIDTH-1:0] bank_rdata [N_BANKS];
    logic [N_BANKS-1:0]    unused_add;

    logic [PtrW-1:0]       rr_q [N_BANKS];
    logic [PtrW-1:0]       rr_d [N_BANKS];
    logic [31:0]           cnt_q, cnt_d;

    logic [MP-1:0]         valid_q;
    logic [MP-1:0]         rd_q;
    logic [BankW-1:0]      sel_q [MP];
    logic [DATA_WIDTH-1:0] s0_data [MP];

    // Port unpacking, address decode and response drive.
    for (genvar p = 0; p < MP; p++) begin : g_port
        assign req[p]          = tcdm[p].req;
        assign port_req[p].add  = tcdm[p].add;
        assign port_req[p].wen  = tcdm[p].wen;
        assign port_req[p].be   = tcdm[p].be;
        assign port_req[p].data = tcdm[p].data;
        assign port_bank[p]     = tcdm[p].add[OffW +: BankW];
        assign unused_ready[p]  = tcdm[p].r_ready;

        assign tcdm[p].gnt    = gnt[p];
        assign tcdm[p].r_user = 1'b0;
        assign tcdm[p].r_id   = 1'b0;
        assign tcdm[p].r_opc  = 1'b0;
        assign tcdm[p].ecc    = 1'b0;

        // Write responses return zero data; reads return the bank's registered word.
        assign s0_data[p] = (valid_q[p] && rd_q[p]) ? bank_rdata[sel_q[p]] : '0;

        if (LATENCY > 1) begin : g_dly
            logic [LATENCY-2:0]    v_q;
            logic [DATA_WIDTH-1:0] d_q [LATENCY-1];

            // Extra response delay stages, flushed by clear.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    v_q <= '0;
                    for (int i = 0; i < LATENCY - 1; i++) d_q[i] <= '0;
                end else if (clear_i) begin
                    v_q <= '0;
                    for (int i = 0; i < LATENCY - 1; i++) d_q[i] <= '0;
                end else begin
                    v_q[0] <= valid_q[p];
                    d_q[0] <= s0_data[p];
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        v_q[i] <= v_q[i-1];
                        d_q[i] <= d_q[i-1];
                    end
                end
            end

            assign tcdm[p].r_valid = v_q[LATENCY-2];
            assign tcdm[p].r_data  = d_q[LATENCY-2];
        end else begin : g_nodly
            assign tcdm[p].r_valid = valid_q[p];
            assign tcdm[p].r_data  = s0_data[p];
        end
    end

    assign elig = req & ~stall_i;

    // Per-bank round-robin: first eligible port at or after the bank pointer wins.
    always_comb begin
        logic [PtrW:0]   idx;
        logic [PtrW-1:0] cand;
        bank_gnt     = '0;
        port_gnt_raw = '0;
        idx          = '0;
        cand         = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            bank_win[b] = '0;
            for (int k = 0; k < MP; k++) begin
                idx = {1'b0, rr_q[b]} + (PtrW+1)'(k);
                if (idx >= (PtrW+1)'(MP)) idx = idx - (PtrW+1)'(MP);
                cand = idx[PtrW-1:0];
                if (!bank_gnt[b] && elig[cand] && (port_bank[cand] == BankW'(b))) begin
                    bank_gnt[b] = 1'b1;
                    bank_win[b] = cand;
                end
            end
            if (bank_gnt[b]) port_gnt_raw[bank_win[b]] = 1'b1;
        end
    end

    // Clear suppresses same-cycle grants; reset drops grants asynchronously.
    assign gnt = port_gnt_raw & {MP{rst_ni & ~clear_i}};

    // Route each bank's winning request to the bank.
    always_comb begin
        for (int b = 0; b < N_BANKS; b++) begin
            bank_req[b] = '0;
            if (bank_gnt[b]) bank_req[b] = port_req[bank_win[b]];
        end
    end

    // Pointer advance and saturating conflict count.
    always_comb begin
        logic [31:0] n_denied;
        logic [32:0] cnt_sum;
        n_denied = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            rr_d[b] = rr_q[b];
            if (bank_gnt[b]) begin
                rr_d[b] = (bank_win[b] == PtrW'(MP - 1)) ? '0 : bank_win[b] + 1'b1;
            end
        end
        for (int p = 0; p < MP; p++) begin
            n_denied = n_denied + 32'(elig[p] & ~port_gnt_raw[p]);
        end
        cnt_sum = {1'b0, cnt_q} + {1'b0, n_denied};
        cnt_d   = cnt_sum[32] ? '1 : cnt_sum[31:0];
        if (clear_i) begin
            cnt_d = '0;
            for (int b = 0; b < N_BANKS; b++) rr_d[b] = '0;
        end
    end

    // Arbitration state and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            for (int b = 0; b < N_BANKS; b++) rr_q[b] <= '0;
        end else begin
            cnt_q <= cnt_d;
            rr_q  <= rr_d;
        end
    end

    // First response stage: remember which grants were reads and from which bank.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            rd_q    <= '0;
            for (int p = 0; p < MP; p++) sel_q[p] <= '0;
        end else begin
            valid_q <= clear_i ? '0 : port_gnt_raw;
            for (int p = 0; p < MP; p++) begin
                rd_q[p]  <= port_req[p].wen;
                sel_q[p] <= port_bank[p];
            end
        end
    end

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        logic [RowW-1:0] row;

        assign row = bank_req[b].add[OffW+BankW +: RowW];
        // Byte-offset and wrapped upper address bits carry no meaning inside a bank.
        assign unused_add[b] = ^{bank_req[b].add[TCDM_AW-1:OffW+BankW+RowW],
                                 bank_req[b].add[OffW+BankW-1:0]};

        fir_tcdm_responder_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .NB_WORDS   (NB_WORDS_PER_BANK)
        ) u_bank (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .req_i   (bank_gnt[b] & ~clear_i),
            .wen_i   (bank_req[b].wen),
            .be_i    (bank_req[b].be),
            .row_i   (row),
            .wdata_i (bank_req[b].data),
            .rdata_o (bank_rdata[b])
        );
    end

    assign n_conflicts_o = cnt_q;

endmodule

// File: tb/tb_fir_tcdm_responder.sv
// Directed bench for fir_tcdm_responder (3 ports, 4 banks, LATENCY=3).
module tb_fir_tcdm_responder;

    localparam int unsigned MP  = 3;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic [MP-1:0] stall = '0;
    logic [31:0]   n_conf;

    logic [MP-1:0] req = '0;
    logic [MP-1:0] wen = '0;
    logic [31:0]   add  [MP];
    logic [3:0]    be   [MP];
    logic [31:0]   data [MP];
    logic [MP-1:0] gnt;
    logic [MP-1:0] rvalid;
    logic [31:0]   rdata [MP];
    logic [3:0]    side  [MP];

    int n_tests = 0;
    int n_fail  = 0;

    fir_tcdm_responder_if #(.DW(DW), .AW(32)) tcdm [MP] ();

    for (genvar g = 0; g < MP; g++) begin : g_if
        assign tcdm[g].req     = req[g];
        assign tcdm[g].add     = add[g];
        assign tcdm[g].wen     = wen[g];
        assign tcdm[g].be      = be[g];
        assign tcdm[g].data    = data[g];
        assign tcdm[g].r_ready = 1'b1;
        assign gnt[g]    = tcdm[g].gnt;
        assign rvalid[g] = tcdm[g].r_valid;
        assign rdata[g]  = tcdm[g].r_data;
        assign side[g]   = {tcdm[g].r_user, tcdm[g].r_id, tcdm[g].r_opc, tcdm[g].ecc};
    end

    fir_tcdm_responder #(
        .MP                (MP),
        .DATA_WIDTH        (DW),
        .N_BANKS           (4),
        .NB_WORDS_PER_BANK (1024),
        .LATENCY           (LAT)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .stall_i       (stall),
        .tcdm          (tcdm),
        .n_conflicts_o (n_conf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        req[p]  = 1'b1;
        wen[p]  = w;
        add[p]  = a;
        be[p]   = b;
        data[p] = d;
    endtask

    task automatic test_reset();
        drive(0, 1'b1, 32'h0, 4'hF, 32'h0);
        #12;
        n_tests++;
        if (gnt !== 3'b000) begin
            n_fail++; $display("FAIL reset_gnt: got %b expected 000", gnt);
        end
        n_tests++;
        if (rvalid !== 3'b000) begin
            n_fail++; $display("FAIL reset_rvalid: got %b expected 000", rvalid);
        end
        for (int p = 0; p < MP; p++) begin
            n_tests++;
            if (rdata[p] !== 32'h0) begin
                n_fail++; $display("FAIL reset_rdata%0d: got %h expected 0", p, rdata[p]);
            end
            n_tests++;
            if (side[p] !== 4'h0) begin
                n_fail++; $display("FAIL reset_side%0d: got %h expected 0", p, side[p]);
            end
        end
        n_tests++;
        if (n_conf !== 32'd0) begin
            n_fail++; $display("FAIL reset_conf: got %0d expected 0", n_conf);
        end
        req = '0;
        #8 rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        step();
        drive(0, 1'b0, 32'h100, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b001) begin
            n_fail++; $display("FAIL wr_gnt: got %b expected 001", gnt);
        end
        step();
        drive(0, 1'b1, 32'h100, 4'hF, 32'h0);
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b001) begin
            n_fail++; $display("FAIL rd_gnt: got %b expected 001", gnt);
        end
        step();
        req = '0;
        @(negedge clk);
        n_tests++;
        if (rvalid !== 3'b000) begin
            n_fail++; $display("FAIL wr_early_rvalid: got %b expected 000", rvalid);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (rvalid !== 3'b001 || rdata[0] !== 32'h0) begin
            n_fail++; $display("FAIL wr_resp: got %b/%h expected 001/00000000", rvalid, rdata[0]);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (rvalid !== 3'b001 || rdata[0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rd_resp: got %b/%h expected 001/deadbeef", rvalid, rdata[0]);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (rvalid !== 3'b000) begin
            n_fail++; $display("FAIL rd_resp_end: got %b expected 000", rvalid);
        end
    endtask

    task automatic test_byte_enable();
        step();
        drive(2, 1'b0, 32'h204, 4'hF, 32'h11223344);
        step();
        drive(2, 1'b0, 32'h204, 4'h5, 32'hAABBCCDD);
        step();
        drive(2, 1'b1, 32'h204, 4'hF, 32'h0);
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b100) begin
            n_fail++; $display("FAIL be_rd_gnt: got %b expected 100", gnt);
        end
        step();
        req = '0;
        @(negedge clk);
        n_tests++;
        if (rvalid !== 3'b100 || rdata[2] !== 32'h0) begin
            n_fail++; $display("FAIL be_wr1_resp: got %b/%h expected 100/0", rvalid, rdata[2]);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (rvalid !== 3'b100 || rdata[2] !== 32'h0) begin
            n_fail++; $display("FAIL be_wr2_resp: got %b/%h expected 100/0", rvalid, rdata[2]);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (rvalid !== 3'b100 || rdata[2] !== 32'h11BB33DD) begin
            n_fail++; $display("FAIL be_rd_resp: got %b/%h expected 100/11bb33dd", rvalid, rdata[2]);
        end
        step();
    endtask

    task automatic test_round_robin();
        step();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        drive(0, 1'b1, 32'h00, 4'hF, 32'h0);
        drive(1, 1'b1, 32'h10, 4'hF, 32'h0);
        drive(2, 1'b1, 32'h20, 4'hF, 32'h0);
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b001 || n_conf !== 32'd0) begin
            n_fail++; $display("FAIL rr_c0: got %b/%0d expected 001/0", gnt, n_conf);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b010 || n_conf !== 32'd2) begin
            n_fail++; $display("FAIL rr_c1: got %b/%0d expected 010/2", gnt, n_conf);
        end
        step();
        req[1] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b100 || n_conf !== 32'd4) begin
            n_fail++; $display("FAIL rr_c2: got %b/%0d expected 100/4", gnt, n_conf);
        end
        step();
        req[2] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b001 || n_conf !== 32'd5) begin
            n_fail++; $display("FAIL rr_c3: got %b/%0d expected 001/5", gnt, n_conf);
        end
        step();
        req = '0;
        @(negedge clk);
        n_tests++;
        if (n_conf !== 32'd5) begin
            n_fail++; $display("FAIL rr_idle_conf: got %0d expected 5", n_conf);
        end
        for (int i = 0; i < 5; i++) step();
    endtask

    task automatic test_interleave();
        step();
        drive(0, 1'b0, 32'h0, 4'hF, 32'hA0A0A0A0);
        drive(1, 1'b0, 32'h4, 4'hF, 32'hB1B1B1B1);
        drive(2, 1'b0, 32'h8, 4'hF, 32'hC2C2C2C2);
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b111) begin
            n_fail++; $display("FAIL il_gnt: got %b expected 111", gnt);
        end
        step();
        req = '0;
        @(negedge clk);
        n_tests++;
        if (n_conf !== 32'd5) begin
            n_fail++; $display("FAIL il_conf: got %0d expected 5", n_conf);
        end
        step();
        step();
        @(negedge clk);
        n_tests++;
        if (rvalid !== 3'b111 || {rdata[0], rdata[1], rdata[2]} !== 96'h0) begin
            n_fail++; $display("FAIL il_resp: got %b/%h%h%h expected 111/0", rvalid,
                               rdata[0], rdata[1], rdata[2]);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (rvalid !== 3'b000) begin
            n_fail++; $display("FAIL il_resp_end: got %b expected 000", rvalid);
        end
    endtask

    task automatic test_stall_wrap();
        step();
        stall = 3'b001;
        drive(0, 1'b1, 32'h4000, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (gnt !== 3'b000 || n_conf !== 32'd5) begin
                n_fail++; $display("FAIL stall_c%0d: got %b/%0d expected 000/5", i, gnt, n_conf);
            end
            step();
        end
        stall = '0;
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b001) begin
            n_fail++; $display("FAIL stall_release_gnt: got %b expected 001", gnt);
        end
        step();
        req = '0;
        step();
        step();
        @(negedge clk);
        n_tests++;
        if (rvalid !== 3'b001 || rdata[0] !== 32'hA0A0A0A0) begin
            n_fail++; $display("FAIL wrap_rd: got %b/%h expected 001/a0a0a0a0", rvalid, rdata[0]);
        end
        step();
    endtask

    task automatic test_clear();
        step();
        drive(1, 1'b1, 32'h4, 4'hF, 32'h0);
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b010) begin
            n_fail++; $display("FAIL clr_rd_gnt: got %b expected 010", gnt);
        end
        step();
        req   = '0;
        clear = 1'b1;
        drive(0, 1'b0, 32'h0, 4'hF, 32'hFFFFFFFF);
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b000) begin
            n_fail++; $display("FAIL clr_gnt_blocked: got %b expected 000", gnt);
        end
        step();
        clear = 1'b0;
        req   = '0;
        @(negedge clk);
        n_tests++;
        if (n_conf !== 32'd0) begin
            n_fail++; $display("FAIL clr_conf: got %0d expected 0", n_conf);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rvalid !== 3'b000) begin
                n_fail++; $display("FAIL clr_flush%0d: got %b expected 000", i, rvalid);
            end
            step();
            @(negedge clk);
        end
        step();
        drive(1, 1'b1, 32'h04, 4'hF, 32'h0);
        drive(2, 1'b1, 32'h14, 4'hF, 32'h0);
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b010) begin
            n_fail++; $display("FAIL clr_rr_reset: got %b expected 010", gnt);
        end
        step();
        req[1] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b100 || n_conf !== 32'd1) begin
            n_fail++; $display("FAIL clr_rr_next: got %b/%0d expected 100/1", gnt, n_conf);
        end
        step();
        req = '0;
        step();
        @(negedge clk);
        n_tests++;
        if (rvalid !== 3'b010 || rdata[1] !== 32'hB1B1B1B1) begin
            n_fail++; $display("FAIL clr_mem_kept: got %b/%h expected 010/b1b1b1b1", rvalid, rdata[1]);
        end
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_async_reset();
        step();
        drive(0, 1'b1, 32'h0, 4'hF, 32'h0);
        step();
        step();
        step();
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b001 || rvalid !== 3'b001 || rdata[0] !== 32'hA0A0A0A0) begin
            n_fail++; $display("FAIL arst_pre: got %b/%b/%h expected 001/001/a0a0a0a0",
                               gnt, rvalid, rdata[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (gnt !== 3'b000 || rvalid !== 3'b000 || rdata[0] !== 32'h0) begin
            n_fail++; $display("FAIL arst_drop: got %b/%b/%h expected 000/000/0",
                               gnt, rvalid, rdata[0]);
        end
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int p = 0; p < MP; p++) begin
            add[p]  = '0;
            be[p]   = '0;
            data[p] = '0;
        end
        test_reset();
        test_write_read();
        test_byte_enable();
        test_round_robin();
        test_interleave();
        test_stall_wrap();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
